// File: rtl/bus_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module  : bus_arbiter_pkg
// Brief   : Shared encodings and widths for the two-requester bus arbiter.
// Revision: 1.0
// ============================================================================
package bus_arbiter_pkg;

  localparam int unsigned c_ADDR_W = 14;
  localparam int unsigned c_DATA_W = 8;

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_BUSY = 2'd1;
  localparam logic [1:0] c_DONE = 2'd2;

  localparam logic [c_DATA_W-1:0] c_TO_RD_DATA = 8'hFF;

endpackage : bus_arbiter_pkg
`default_nettype wire

// File: rtl/bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : bus_arbiter
// Brief   : Round-robin arbiter of two requesters onto one register bus,
//           with a per-transaction timeout that forces an error completion.
// Revision: 1.0
// ============================================================================
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,

  input  logic                m0_stb,
  input  logic                m0_wr,
  input  logic [c_ADDR_W-1:0] m0_a,
  input  logic [c_DATA_W-1:0] m0_d,
  output logic                m0_ack,
  output logic                m0_err,

  input  logic                m1_stb,
  input  logic                m1_wr,
  input  logic [c_ADDR_W-1:0] m1_a,
  input  logic [c_DATA_W-1:0] m1_d,
  output logic                m1_ack,
  output logic                m1_err,

  output logic [c_DATA_W-1:0] m_rd_d,

  output logic                s_stb,
  input  logic                s_ack,
  output logic                s_wr,
  output logic [c_ADDR_W-1:0] s_a,
  output logic [c_DATA_W-1:0] s_d,
  input  logic [c_DATA_W-1:0] s_rd_d
);

  localparam logic [7:0] c_CNT_LAST = 8'(TIMEOUT - 1);

  logic [1:0] r_state;
  logic [1:0] w_next_state;
  logic       r_last;
  logic       r_grant;
  logic [7:0] r_cnt;

  logic       w_pick;
  logic       w_start;
  logic       w_ack_hit;
  logic       w_to_hit;
  logic       w_finish;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_IDLE:  if (m0_stb || m1_stb) w_next_state = c_BUSY;
      c_BUSY:  if (w_finish)         w_next_state = c_DONE;
      c_DONE:                        w_next_state = c_IDLE;
      default:                       w_next_state = c_IDLE;
    endcase
  end

  // Control decode; on a tie the requester not granted last wins
  always_comb begin
    w_pick = 1'b0;
    if (m0_stb && m1_stb) begin
      w_pick = ~r_last;
    end else if (m1_stb) begin
      w_pick = 1'b1;
    end
    w_start   = (r_state == c_IDLE) && (m0_stb || m1_stb);
    w_ack_hit = (r_state == c_BUSY) && s_ack;
    w_to_hit  = (r_state == c_BUSY) && !s_ack && (r_cnt == c_CNT_LAST);
    w_finish  = w_ack_hit || w_to_hit;
  end

  // Registered bus side, completion pulses and read-data capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last  <= 1'b1;
      r_grant <= 1'b0;
      r_cnt   <= 8'd0;
      s_stb   <= 1'b0;
      s_wr    <= 1'b0;
      s_a     <= '0;
      s_d     <= '0;
      m0_ack  <= 1'b0;
      m1_ack  <= 1'b0;
      m0_err  <= 1'b0;
      m1_err  <= 1'b0;
      m_rd_d  <= '0;
    end else begin
      m0_ack <= 1'b0;
      m1_ack <= 1'b0;
      m0_err <= 1'b0;
      m1_err <= 1'b0;

      if (w_start) begin
        s_stb   <= 1'b1;
        r_grant <= w_pick;
        r_cnt   <= 8'd0;
        s_wr    <= w_pick ? m1_wr : m0_wr;
        s_a     <= w_pick ? m1_a  : m0_a;
        s_d     <= w_pick ? m1_d  : m0_d;
      end

      if (r_state == c_BUSY) begin
        r_cnt <= r_cnt + 8'd1;
      end

      if (w_finish) begin
        s_stb  <= 1'b0;
        r_last <= r_grant;
        m0_ack <= ~r_grant;
        m1_ack <= r_grant;
        m0_err <= w_to_hit && !r_grant;
        m1_err <= w_to_hit && r_grant;
        m_rd_d <= w_ack_hit ? s_rd_d : c_TO_RD_DATA;
      end
    end
  end

endmodule : bus_arbiter
`default_nettype wire

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 The parameters SHALL be, one per line: name, default, meaning.
  TIMEOUT  255  cycles in BUSY with no s_ack before forced completion, legal range 2..255.
REQ-002 The ports SHALL be, one per line: name  direction  width  meaning.
  clk  in  1  single clock; all state changes on rising edge.
  rst  in  1  asynchronous, active-high reset.
  m0_stb, m1_stb  in  1  requester n holds a transaction; held until its m_ack.
  m0_wr, m1_wr  in  1  1=write, 0=read.
  m0_a, m1_a  in  14  register address.
  m0_d, m1_d  in  8  write data.
  m0_ack, m1_ack  out  1  one-cycle completion pulse.
  m0_err, m1_err  out  1  one-cycle pulse with m_ack on timeout.
  m_rd_d  out  8  read data, valid in the m_ack cycle, shared by both requesters.
  s_stb  out  1  downstream register-bus strobe.
  s_ack  in  1  downstream completion.
  s_wr  out  1  downstream write flag.
  s_a  out  14  downstream address.
  s_d  out  8  downstream write data.
  s_rd_d  in  8  downstream read data, valid with s_ack.

Function
REQ-003 FSM states SHALL be IDLE, BUSY and DONE.
REQ-004 IDLE with any m_stb high SHALL register the winner's wr/a/d onto s_wr/s_a/s_d, set grant to the winner, set s_stb=1 and enter BUSY, all on the same edge.
REQ-005 Arbitration SHALL be round-robin:
  - with one request pending, that requester wins;
  - with both pending, the requester not granted last wins;
  - the last-grant register resets to 1, so m0 wins the first tie.
REQ-006 s_wr, s_a and s_d SHALL hold stable while s_stb=1, regardless of requester input changes.
REQ-007 In BUSY, the first edge with s_ack=1 SHALL:
  - clear s_stb;
  - pulse m<grant>_ack for one cycle;
  - load m_rd_d from s_rd_d;
  - update last-grant;
  - enter DONE.
REQ-008 BUSY SHALL count cycles from 0; when the count reaches TIMEOUT-1 with s_ack=0, the next edge SHALL clear s_stb, pulse m<grant>_ack and m<grant>_err, load m_rd_d=8'hFF, update last-grant and enter DONE.
REQ-009 s_ack and the timeout in the same cycle SHALL complete normally with no err.
REQ-010 DONE SHALL last exactly one cycle and return to IDLE, so the completed requester's stale stb is never re-granted; the other requester's request is honoured in the following IDLE.
REQ-011 Minimum transaction latency SHALL be:
  - m_stb sampled at edge 0 gives s_stb high after edge 0;
  - s_ack sampled at edge k gives m_ack high after edge k;
  - the next grant occurs no earlier than edge k+2.
REQ-012 s_ack outside BUSY SHALL be ignored.
REQ-013 m_rd_d SHALL hold its value between completions, including for writes (it loads s_rd_d on any ack).
REQ-014 The timeout counter SHALL be 8 bits and SHALL clear on entry to BUSY.

Reset
REQ-015 rst=1 SHALL asynchronously force:
  - state=IDLE, last-grant=1, counter=0;
  - s_stb=0, m0_ack=m1_ack=0, m0_err=m1_err=0;
  - s_wr=0, s_a=0, s_d=0, m_rd_d=0.
REQ-016 Reset asserted mid-BUSY SHALL abandon the transaction with no ack pulse; after release, a still-held m_stb is re-arbitrated from IDLE.

Structure
REQ-017 A shared package SHALL hold the FSM state encodings (IDLE=2'd0, BUSY=2'd1, DONE=2'd2), the address width 14, the data width 8 and the timeout read value 8'hFF.
REQ-018 The block SHALL be a single module with no sub-modules; the round-robin pick is inline combinational logic.

Verification
REQ-019 Single write: m0 wr=1, a=14'h0123, d=8'hA5, s_ack returned 2 cycles after s_stb -> s_a=14'h0123, s_d=8'hA5, s_wr=1, m0_ack pulses once, m0_err=0.
REQ-020 Contention: m0 and m1 held continuously, s_ack given immediately each time -> grants alternate m0, m1, m0, m1 with one DONE cycle between them.
REQ-021 Read: m1 wr=0, a=14'h3FFF, s_rd_d=8'h3C with s_ack -> m_rd_d=8'h3C in the m1_ack cycle and held afterwards.
REQ-022 Timeout: TIMEOUT=4, s_ack never asserted -> s_stb high exactly 4 cycles, then m0_ack and m0_err pulse together with m_rd_d=8'hFF.
REQ-023 Timeout collision: TIMEOUT=4, s_ack in the 4th BUSY cycle -> m0_ack with m0_err=0 and m_rd_d=s_rd_d.
REQ-024 Reset mid-BUSY: rst pulsed while s_stb=1 -> s_stb drops immediately with no m_ack; m0_stb still high -> re-granted once rst is low.
